// File: rtl/ahb_decoder_mux_if.sv
// ----------------------------------------------------------------------------
// ahb_decoder_mux_if
// Bundles the AHB-Lite signals between one master, the address decoder /
// response mux, and NUM_SLV slaves.
//
//   haddr, htrans   master address phase
//   hready          bus HREADY as seen by everybody (normally hready_out)
//   hsel            one-hot slave select from the decoder
//   hrdata_s        per-slave read data (unpacked array)
//   hreadyout_s     per-slave HREADYOUT
//   hresp_s         per-slave HRESP (1 = ERROR)
//   hrdata          muxed read data to the master
//   hready_out      muxed HREADY
//   hresp           muxed HRESP
//
// Modports:
//   master : the bus fabric around the decoder (master plus slaves); it
//            drives the address phase and the slave responses.
//   slave  : the decoder/mux block itself.
// ----------------------------------------------------------------------------
interface ahb_decoder_mux_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [ADDR_W-1:0]  haddr;
  logic [1:0]         htrans;
  logic               hready;
  logic [NUM_SLV-1:0] hsel;
  logic [DATA_W-1:0]  hrdata_s [NUM_SLV];
  logic [NUM_SLV-1:0] hreadyout_s;
  logic [NUM_SLV-1:0] hresp_s;
  logic [DATA_W-1:0]  hrdata;
  logic               hready_out;
  logic               hresp;

  modport master (
    output haddr, htrans, hready, hrdata_s, hreadyout_s, hresp_s,
    input  hsel, hrdata, hready_out, hresp
  );

  modport slave (
    input  haddr, htrans, hready, hrdata_s, hreadyout_s, hresp_s,
    output hsel, hrdata, hready_out, hresp
  );
endinterface

// File: rtl/ahb_decoder_mux.sv
// ----------------------------------------------------------------------------
// ahb_decoder_mux
// AHB-Lite address decoder and response multiplexer for one master and
// NUM_SLV slaves, with a built-in default slave for unmapped addresses.
//
// Slave i owns [BASE_ADDR + i*2^REGION_BITS, BASE_ADDR + (i+1)*2^REGION_BITS).
//
// Ports:
//   hclk     bus clock, all state on the rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_decoder_mux_if.slave (address phase in, hsel out,
//            slave responses in, muxed response out)
// ----------------------------------------------------------------------------
module ahb_decoder_mux #(
  parameter int              NUM_SLV     = 4,
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              REGION_BITS = 12
) (
  input  logic              hclk,
  input  logic              hresetn,
  ahb_decoder_mux_if.slave  bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  // Default-slave FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } dsel_t;

  logic [ADDR_W-1:0]  off;
  logic [ADDR_W-1:0]  idx_full;
  logic               mapped;
  logic [IDX_W-1:0]   idx;
  logic [NUM_SLV-1:0] hsel_c;
  logic               start_err;

  dsel_t      dsel;
  logic       dflt;
  logic [1:0] state;
  logic [1:0] state_nxt;

  // --------------------------------------------------------------------------
  // Address decode. The subtraction is done in ADDR_W bits; an address below
  // BASE_ADDR wraps to a huge offset, but the explicit >= test rejects it
  // anyway so a wrap can never alias onto a real region.
  // --------------------------------------------------------------------------
  always_comb begin
    off       = bus.haddr - BASE_ADDR;
    idx_full  = off >> REGION_BITS;
    mapped    = (bus.haddr >= BASE_ADDR) && (idx_full < ADDR_W'(NUM_SLV));
    idx       = idx_full[IDX_W-1:0];
    start_err = ~mapped & bus.htrans[1];
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    hsel_c = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (mapped && (idx == IDX_W'(i))) hsel_c[i] = 1'b1;
    end
  end

  assign bus.hsel = hsel_c;

  // --------------------------------------------------------------------------
  // Data-phase select: captured only when the previous transfer completes.
  // --------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel <= '0;
      dflt <= 1'b0;
    end else if (bus.hready) begin
      dsel <= '{valid: mapped, idx: idx};
      dflt <= start_err;
    end
  end

  // --------------------------------------------------------------------------
  // Default slave: two-cycle ERROR response. ERR1 stretches the data phase
  // (hready low) so the address phase is sampled again only in ERR2, which
  // lets back-to-back unmapped transfers chain straight into ERR1.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = (bus.hready && start_err) ? S_ERR1 : S_IDLE;
      S_ERR1: state_nxt = S_ERR2;
      S_ERR2: state_nxt = (bus.hready && start_err) ? S_ERR1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Response mux. dflt qualifies the FSM outputs: the error response is only
  // presented when the captured data phase really was an unmapped transfer.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.hrdata     = '0;
    bus.hready_out = 1'b1;
    bus.hresp      = 1'b0;
    if (dsel.valid) begin
      bus.hrdata     = bus.hrdata_s[dsel.idx];
      bus.hready_out = bus.hreadyout_s[dsel.idx];
      bus.hresp      = bus.hresp_s[dsel.idx];
    end else begin
      bus.hready_out = ~(dflt && (state == S_ERR1));
      bus.hresp      = dflt && (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_decoder_mux
// Directed scoreboard bench. The stimulus process drives one cycle at a time
// and pushes the response it expects to see in that cycle; a monitor pops
// and compares on every falling edge (or on an explicit trigger for the
// asynchronous reset check).
// ----------------------------------------------------------------------------
module tb_ahb_decoder_mux;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;

  logic hclk;
  logic hresetn;

  ahb_decoder_mux_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb_decoder_mux #(
    .NUM_SLV(4), .ADDR_W(32), .DATA_W(32),
    .BASE_ADDR(32'h0000_0000), .REGION_BITS(12)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus.slave)
  );

  // HREADY is fed back from the mux, as the top level of a real bus would.
  assign bus.hready = bus.hready_out;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    string       name;
    logic [3:0]  hsel;
    logic [31:0] rdata;
    logic        rdy;
    logic        rsp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  event chk_ev;

  task automatic cmp(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %h expected %h", name, fld, act, exp);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk or chk_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "hsel",       32'(bus.hsel),       32'(e.hsel));
        cmp(e.name, "hrdata",     bus.hrdata,          e.rdata);
        cmp(e.name, "hready_out", 32'(bus.hready_out), 32'(e.rdy));
        cmp(e.name, "hresp",      32'(bus.hresp),      32'(e.rsp));
      end
    end
  end

  task automatic push(input string name, input logic [3:0] ehsel,
                      input logic [31:0] erd, input logic erdy, input logic ersp);
    exp_t e;
    e.name  = name;
    e.hsel  = ehsel;
    e.rdata = erd;
    e.rdy   = erdy;
    e.rsp   = ersp;
    q.push_back(e);
  endtask

  // One bus cycle: drive just after the rising edge, queue the expected
  // outputs for this same cycle.
  task automatic cyc(input string name, input logic rst,
                     input logic [31:0] addr, input logic [1:0] trans,
                     input logic [3:0] rdyo, input logic [3:0] rsp,
                     input logic [3:0] ehsel, input logic [31:0] erd,
                     input logic erdy, input logic ersp);
    @(posedge hclk);
    #1;
    hresetn         = rst;
    bus.haddr       = addr;
    bus.htrans      = trans;
    bus.hreadyout_s = rdyo;
    bus.hresp_s     = rsp;
    push(name, ehsel, erd, erdy, ersp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn         = 1'b0;
    bus.haddr       = '0;
    bus.htrans      = IDLE;
    bus.hreadyout_s = 4'b0000;
    bus.hresp_s     = 4'b1111;
    for (int i = 0; i < 4; i++) bus.hrdata_s[i] = 32'hCAFE_0000 + 32'(i);

    // Reset with hostile slave responses: default outputs must win.
    cyc("rst0", 1'b0, 32'h0000, IDLE, 4'b0000, 4'b1111, 4'b0001, 32'h0, 1'b1, 1'b0);
    cyc("rst1", 1'b0, 32'h0000, IDLE, 4'b0000, 4'b1111, 4'b0001, 32'h0, 1'b1, 1'b0);
    cyc("rel",  1'b1, 32'h0000, IDLE, 4'b1111, 4'b0000, 4'b0001, 32'h0, 1'b1, 1'b0);

    // Decode sweep (IDLE transfers still route to the mapped slave).
    cyc("dec0000", 1'b1, 32'h0000, IDLE, 4'b1111, 4'b0000, 4'b0001, 32'hCAFE_0000, 1'b1, 1'b0);
    cyc("dec1FFC", 1'b1, 32'h1FFC, IDLE, 4'b1111, 4'b0000, 4'b0010, 32'hCAFE_0000, 1'b1, 1'b0);
    cyc("dec2000", 1'b1, 32'h2000, IDLE, 4'b1111, 4'b0000, 4'b0100, 32'hCAFE_0001, 1'b1, 1'b0);
    cyc("dec3FFF", 1'b1, 32'h3FFF, IDLE, 4'b1111, 4'b0000, 4'b1000, 32'hCAFE_0002, 1'b1, 1'b0);
    cyc("dec4000", 1'b1, 32'h4000, IDLE, 4'b1111, 4'b0000, 4'b0000, 32'hCAFE_0003, 1'b1, 1'b0);

    // Read routing; previous phase was unmapped IDLE -> zero-wait OKAY.
    cyc("rd2010",  1'b1, 32'h2010, NONSEQ, 4'b1111, 4'b0000, 4'b0100, 32'h0, 1'b1, 1'b0);
    cyc("rd1000",  1'b1, 32'h1000, NONSEQ, 4'b1111, 4'b0000, 4'b0010, 32'hCAFE_0002, 1'b1, 1'b0);

    // Slave 1 inserts three wait states while NONSEQ 0x3000 is held.
    cyc("wait1",   1'b1, 32'h3000, NONSEQ, 4'b1101, 4'b0000, 4'b1000, 32'hCAFE_0001, 1'b0, 1'b0);
    cyc("wait2",   1'b1, 32'h3000, NONSEQ, 4'b1101, 4'b0000, 4'b1000, 32'hCAFE_0001, 1'b0, 1'b0);
    cyc("wait3",   1'b1, 32'h3000, NONSEQ, 4'b1101, 4'b0000, 4'b1000, 32'hCAFE_0001, 1'b0, 1'b0);
    cyc("wdone",   1'b1, 32'h3000, NONSEQ, 4'b1111, 4'b0000, 4'b1000, 32'hCAFE_0001, 1'b1, 1'b0);

    // Unmapped NONSEQ -> ERR1/ERR2, chained back-to-back, then master drops
    // to IDLE during ERR1.
    cyc("to_s3",   1'b1, 32'h8000, NONSEQ, 4'b1111, 4'b0000, 4'b0000, 32'hCAFE_0003, 1'b1, 1'b0);
    cyc("err1a",   1'b1, 32'h8000, NONSEQ, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);
    cyc("err2a",   1'b1, 32'h9000, NONSEQ, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
    cyc("err1b",   1'b1, 32'h9000, IDLE,   4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);
    cyc("err2b",   1'b1, 32'h9000, IDLE,   4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
    cyc("unm_idl", 1'b1, 32'hA000, NONSEQ, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0);
    cyc("err1c",   1'b1, 32'hA000, NONSEQ, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of ERR1, checked before any edge.
    @(negedge hclk);
    #1;
    hresetn = 1'b0;
    #1;
    push("async_rst", 4'b0000, 32'h0, 1'b1, 1'b0);
    ->chk_ev;

    // Recovery: first post-reset cycle ready, then a normal mapped NONSEQ.
    cyc("post0",   1'b1, 32'h0004, NONSEQ, 4'b1111, 4'b0000, 4'b0001, 32'h0, 1'b1, 1'b0);
    cyc("post1",   1'b1, 32'h0000, IDLE,   4'b1111, 4'b0000, 4'b0001, 32'hCAFE_0000, 1'b1, 1'b0);
    cyc("post2",   1'b1, 32'h0000, IDLE,   4'b1111, 4'b0000, 4'b0001, 32'hCAFE_0000, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge hclk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
- AHB-Lite address decoder and slave-to-master response multiplexer for one master and NUM_SLV slaves.
- Address phase: decodes haddr into a one-hot hsel.
- Data phase: routes the selected slave's hrdata/hreadyout/hresp back to the master. Select is registered on hready.
- Built-in default slave answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.

Parameters:
NUM_SLV, 4, number of slave regions/ports (1..16)
ADDR_W, 32, haddr width
DATA_W, 32, hrdata width
BASE_ADDR, 32'h0000_0000, start address of slave 0 region
REGION_BITS, 12, log2 of region size in bytes (slave i owns BASE_ADDR + i*2^REGION_BITS, size 2^REGION_BITS)

Ports:
hclk  input  1  bus clock, all state on rising edge
hresetn  input  1  asynchronous active-low reset
haddr  input  ADDR_W  master address (address phase)
htrans  input  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hready  input  1  bus HREADY (fed back from hready_out by top level)
hsel  output  NUM_SLV  one-hot slave select, combinational
hrdata_s  input  [DATA_W-1:0] x [NUM_SLV-1:0] unpacked array  per-slave read data
hreadyout_s  input  NUM_SLV  per-slave HREADYOUT
hresp_s  input  NUM_SLV  per-slave HRESP (1=ERROR)
hrdata  output  DATA_W  muxed read data to master
hready_out  output  1  muxed HREADY to master/slaves
hresp  output  1  muxed HRESP to master

Behaviour:
- Decode: off = haddr - BASE_ADDR; idx = off >> REGION_BITS.
  - Mapped iff haddr >= BASE_ADDR and idx < NUM_SLV.
  - hsel[idx]=1 when mapped, otherwise all zero.
  - hsel is purely combinational on haddr and is independent of htrans.
- Data-phase select register dsel (index plus valid flag) and default-slave flag dflt:
  - Update only when hready=1.
  - dsel <= {mapped, idx}.
  - dflt <= ~mapped & htrans[1].
  - When hready=0, both hold.
- Reset (hresetn=0, async): dsel.valid=0, dflt=0, FSM=IDLE. Outputs: hready_out=1, hresp=0, hrdata=0.
- Output mux, dsel.valid=1: hrdata=hrdata_s[dsel.idx], hready_out=hreadyout_s[dsel.idx], hresp=hresp_s[dsel.idx].
  - A mapped IDLE/BUSY still routes to that slave; the slave returns OKAY.
- Output mux, dsel.valid=0: hrdata=0; hready_out and hresp come from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: hready_out=1, hresp=0. Go to ERR1 on the clock edge where hready=1, ~mapped, htrans[1]=1.
  - ERR1: hready_out=0, hresp=1. Always go to ERR2 next cycle.
  - ERR2: hready_out=1, hresp=1. Address phase is sampled this cycle.
    - If that address is again unmapped NONSEQ/SEQ, go to ERR1.
    - Otherwise go to IDLE.
  - Unmapped IDLE/BUSY gives a zero-wait OKAY (FSM stays IDLE).
- Latency: the response to an address phase in cycle N is presented from cycle N+1. No added wait states beyond the slave's own.
- Slave wait states: while hreadyout_s[dsel.idx]=0, dsel holds and hsel keeps tracking haddr. The master must hold haddr per AHB.
- Master changing htrans NONSEQ->IDLE during an ERROR response (ERR1): allowed. ERR2 samples the IDLE and returns to IDLE.
- Reset asserted mid-ERR1/ERR2 or mid-slave-wait: immediately drop to reset values. The first post-reset cycle sees hready_out=1.
- Regions are contiguous and non-overlapping.
- Addresses above the top region wrap nowhere: they are unmapped. off is computed in ADDR_W bits, and haddr < BASE_ADDR is unmapped.

Test Plan:
- Reset: hresetn=0 with hreadyout_s=0 and hresp_s=all 1 -> hready_out=1, hresp=0, hrdata=0, dsel invalid. Release -> still hready_out=1.
- Decode sweep (BASE=0, REGION_BITS=12, NUM_SLV=4): haddr=0x0000, 0x1FFC, 0x2000, 0x3FFF, 0x4000 -> hsel=0001, 0010, 0100, 1000, 0000.
- Read routing: NONSEQ haddr=0x2010, hrdata_s[2]=0xCAFE0002 -> next cycle hrdata=0xCAFE0002, hready_out=1, hresp=0.
- Slave wait states: slave 1 drives hreadyout_s[1]=0 for 3 cycles, then 1. Meanwhile NONSEQ to 0x3000 is held -> hready_out low 3 cycles, slave 1 response, then routing switches to slave 3.
- Unmapped NONSEQ to 0x8000 -> ERR1 (hready_out=0, hresp=1), then ERR2 (1,1), then IDLE. Back-to-back unmapped NONSEQ sampled in ERR2 -> ERR1 again. Unmapped IDLE -> OKAY, zero wait.
- Async reset asserted during ERR1 -> outputs return to 1/0/0 without a clock edge. The next mapped NONSEQ to 0x0004 completes normally.
